// File: rtl/prime_checker.sv
// Sequential trial-division primality checker with valid/ready on both sides.
// Optional PRIME_CHECK_COUNT_EN adds saturating prime/checked verdict counters.
module prime_checker #(
  parameter int WIDTH = 8,
  parameter int DW    = WIDTH/2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             out_is_prime
`ifdef PRIME_CHECK_COUNT_EN
  ,
  output logic [15:0]      prime_count,
  output logic [15:0]      checked_count
`endif
);

  typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [WIDTH-1:0]    n_reg;
  logic [DW-1:0]       d_reg;
  logic [2*DW-1:0]     d_sq;
  logic [WIDTH-1:0]    rem;
  logic                test_done;
  logic                verdict;
  logic                accept;
  logic                handshake;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign handshake = (state_reg == DONE) && out_ready;

  // Square is formed at double divisor width so the bound test never wraps.
  always_comb begin
    d_sq      = (2*DW)'(d_reg) * (2*DW)'(d_reg);
    rem       = n_reg % WIDTH'(d_reg);
    test_done = 1'b0;
    verdict   = 1'b0;
    if (n_reg < WIDTH'(2)) begin
      test_done = 1'b1;
    end else if (d_sq > (2*DW)'(n_reg)) begin
      test_done = 1'b1;
      verdict   = 1'b1;
    end else if (rem == '0) begin
      test_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = TEST;
      TEST:    if (test_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg        <= '0;
      d_reg        <= '0;
      out_num      <= '0;
      out_is_prime <= 1'b0;
    end else begin
      if (accept) begin
        n_reg <= in_num;
        d_reg <= DW'(2);
      end else if (state_reg == TEST) begin
        if (test_done) begin
          out_num      <= n_reg;
          out_is_prime <= verdict;
        end else begin
          d_reg <= d_reg + DW'(1);
        end
      end
    end
  end

`ifdef PRIME_CHECK_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_count   <= '0;
      checked_count <= '0;
    end else if (handshake) begin
      if (checked_count != 16'hFFFF) checked_count <= checked_count + 16'd1;
      if (out_is_prime && prime_count != 16'hFFFF) prime_count <= prime_count + 16'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_prime_checker.sv
// Directed bench for prime_checker: per-cycle comparison against a behavioural
// primality/latency model plus hand-computed literal checks.
module tb_prime_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_num = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_num;
  logic       out_is_prime;
`ifdef PRIME_CHECK_COUNT_EN
  logic [15:0] prime_count;
  logic [15:0] checked_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_verdicts = 0;
  int n_primes   = 0;

  prime_checker #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num       (in_num),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_num      (out_num),
    .out_is_prime (out_is_prime)
`ifdef PRIME_CHECK_COUNT_EN
    ,
    .prime_count  (prime_count),
    .checked_count(checked_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int is_prime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
    return 1;
  endfunction

  // Number of divisors tried before a verdict.
  function automatic int k_of(input int n);
    if (n < 2) return 1;
    for (int d = 2; d < 64; d++) if (d * d > n || n % d == 0) return d - 1;
    return 0;
  endfunction

  // Per-cycle compare against the model.
  initial begin
    bit m_busy = 0;
    int m_num = 0;
    int m_due = 0;
    int exp_pc = 0;
    int exp_cc = 0;
    bit exp_valid;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_num", out_num, 0);
        check("rst_out_is_prime", out_is_prime, 0);
        m_busy = 0;
        exp_pc = 0;
        exp_cc = 0;
      end else begin
        exp_valid = m_busy && (cyc >= m_due);
        check("in_ready", in_ready, m_busy ? 0 : 1);
        check("out_valid", out_valid, exp_valid ? 1 : 0);
        if (exp_valid) begin
          check("out_num", out_num, m_num);
          check("out_is_prime", out_is_prime, is_prime(m_num));
        end
`ifdef PRIME_CHECK_COUNT_EN
        check("prime_count", prime_count, exp_pc);
        check("checked_count", checked_count, exp_cc);
`endif
        if (exp_valid && out_ready) begin
          m_busy = 0;
          n_verdicts++;
          if (out_is_prime) n_primes++;
          if (exp_cc < 65535) exp_cc++;
          if (is_prime(m_num) == 1 && exp_pc < 65535) exp_pc++;
          $display("[TB] verdict num=%0d is_prime=%0d", out_num, out_is_prime);
        end else if (!m_busy && in_valid) begin
          m_busy = 1;
          m_num  = int'(in_num);
          m_due  = cyc + 1 + k_of(int'(in_num));
        end
      end
    end
  end

  task automatic run_one(input int num, input int exp_prime, input int exp_k, input int hold);
    int lat;
    bit seen;
    @(posedge clk); #2;
    in_valid  = 1'b1;
    in_num    = num[7:0];
    out_ready = (hold == 0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    if (!seen) check("accept_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_num   = 8'($urandom);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("ready_low_after_accept", in_ready, 0);
      if (out_valid) seen = 1;
    end
    check("latency_k", lat - 1, exp_k);
    check("lit_out_num", out_num, num);
    check("lit_is_prime", out_is_prime, exp_prime);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_num", out_num, num);
        check("hold_prime", out_is_prime, exp_prime);
        check("hold_ready", in_ready, 0);
      end
      @(posedge clk); #2;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("ready_after_handshake", in_ready, 1);
    $display("[TB] num=%0d k=%0d is_prime=%0d hold=%0d", num, lat - 1, exp_prime, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v;
    int base_p;
    bit seen;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    run_one(2, 1, 1, 0);
    run_one(0, 0, 1, 0);
    run_one(1, 0, 1, 0);
    run_one(4, 0, 1, 0);
    run_one(3, 1, 1, 0);
    run_one(251, 1, 15, 0);
    run_one(221, 0, 12, 0);
    run_one(97, 1, 9, 20);

    // Back-to-back sweep of every 8-bit value.
    base_v = n_verdicts;
    base_p = n_primes;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_num   = 8'(i);
      seen = 0;
      for (int j = 0; j < 40 && !seen; j++) begin
        @(negedge clk);
        if (in_ready) seen = 1;
      end
      if (!seen) check("sweep_accept_timeout", 0, 1);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("sweep_verdicts", n_verdicts - base_v, 256);
    check("sweep_primes", n_primes - base_p, 54);
`ifdef PRIME_CHECK_COUNT_EN
    check("lit_checked_count", checked_count, 256 + base_v);
    check("lit_prime_count", prime_count, 54 + base_p);
`endif

    // Abort a long test with reset.
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_num   = 8'd251;
    seen = 0;
    for (int j = 0; j < 40 && !seen; j++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ready", in_ready, 1);
    check("async_rst_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    check("abort_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
